acc_trim_cal_ctrl: RTL
======================

// Module: acc_trim_cal_ctrl
// PURPOSE
//  Calibration sequencer for the ACC demo-flag trim stage. Sweeps a shared pose/nege trim time and
//  scores each point from the trim stage's ctrl/flag phase-mismatch counters. Applies the lowest-score
//  setting. Outside calibration, passes manual trim times through.
//  Sits between the register file and the trim stage; drives its trim times and pmt_scan_en.
// PARAMETERS
//  SETTLE_CYC   64      cycles held after applying a sweep value before measuring (>=2)
//  WIN_FLAGS    32      acc_demo_flag rising edges per measurement window (1..255)
//  TIMEOUT_CYC  1000000 max cycles between flag rising edges in MEAS before error (<2^24)
// PORTS
//  clk_i             in   1   system clock
//  rst_n_i           in   1   async active-low reset
//  cal_start_i       in   1   1-cycle pulse: start sweep (ignored while busy)
//  cal_abort_i       in   1   level: abort sweep, return to IDLE
//  sweep_start_i     in   16  first trim value
//  sweep_step_i      in   16  increment per point
//  sweep_num_i       in   8   number of points (0 = invalid)
//  manual_pose_i     in   16  trim pose time used while not calibrating
//  manual_nege_i     in   16  trim nege time used while not calibrating
//  acc_demo_flag_i   in   1   raw demo flag (edge counting only)
//  acc_phase_cnt_i   in   32  {ctrl_phase_cnt[31:16], flag_phase_cnt[15:0]} from trim stage
//  pmt_scan_en_o     out  1   scan enable to trim stage; rising edge clears its phase counters
//  trim_pose_o       out  16  trim pose time to trim stage
//  trim_nege_o       out  16  trim nege time to trim stage
//  cal_busy_o        out  1   high in any state except IDLE
//  cal_done_o        out  1   1-cycle pulse on successful completion
//  cal_err_o         out  1   sticky error; cleared on next accepted cal_start_i
//  best_val_o        out  16  best trim value found (valid after done)
//  best_score_o      out  17  score of best_val_o (ctrl+flag, zero-extended sum)
// BEHAVIOUR
//  Reset: state IDLE; pmt_scan_en_o=0, trim outputs=0, busy=0, done=0, err=0, best_val=0, best_score=0x1FFFF.
//  IDLE: trim_pose_o/trim_nege_o register manual_*_i (1-cycle latency). After a successful cal,
//  IDLE drives best_val_o on both instead until the next cal_start_i or reset. scan_en_o=0.
//  cal_start_i in IDLE: latch start/step/num, idx=0, best_score=0x1FFFF, err=0.
//    num==0 -> err=1, stay IDLE, no done pulse.
//  FSM: IDLE -> APPLY -> SETTLE -> ARM -> MEAS -> SCORE -> (APPLY | DONE) -> IDLE.
//  APPLY (1 cyc): trim_pose_o=trim_nege_o=cur_val; cur_val=start+idx*step, accumulated 17-bit.
//  SETTLE: scan_en_o=0 for SETTLE_CYC cycles.
//  ARM (1 cyc): scan_en_o rises; trim stage clears counters on that edge.
//  MEAS: scan_en_o=1; count flag rising edges (synchronised, d0/d1 edge detect).
//    Exit after WIN_FLAGS edges + 2 extra cycles for counter update latency.
//  SCORE (1 cyc): score = acc_phase_cnt_i[31:16] + acc_phase_cnt_i[15:0] (17-bit).
//    If score < best_score (strict; ties keep earlier point): best_score<=score, best_val<=cur_val.
//    idx+1==num -> DONE; else APPLY.
//  DONE (1 cyc): done=1, scan_en_o=0, -> IDLE.
//  Wrap: if the next cur_val exceeds 0xFFFF (17-bit carry), sweep ends early -> DONE with err=1.
//    Points already scored remain valid.
//  Timeout: >TIMEOUT_CYC cycles without a flag edge in MEAS -> err=1, IDLE, no done pulse;
//    outputs revert to manual values.
//  cal_abort_i in any busy state (priority over all transitions): next cycle IDLE, scan_en_o=0,
//    err=1, no done, manual values applied.
//  cal_start_i while busy: ignored. Simultaneous start+abort in IDLE: abort wins, stay IDLE, err unchanged.
//  Async reset mid-sweep: immediate return to reset values.
// TESTING
//  T1 start=100,step=10,num=3; model scores 40,12,30 -> best_val=110, best_score=12, done pulse, err=0.
//  T2 num=0 -> err=1 next cycle, busy never rises, manual 0x0020/0x0030 still on trim outputs.
//  T3 equal scores 5,5 at vals 200,201 -> best_val=200 (tie keeps first).
//  T4 start=0xFFF0,step=0x10,num=4 -> one point scored (0xFFF0), early DONE with err=1.
//  T5 hold flag low in MEAS, TIMEOUT_CYC=100 -> err=1 at cycle 101, IDLE, no done, manual outputs.
//  T6 assert cal_abort_i during SETTLE, then rst_n_i low during MEAS of new run -> IDLE, err=1; then all reset values.

Source files
------------

// File: rtl/acc_trim_cal_ctrl.sv
// rtl/acc_trim_cal_ctrl.sv - trim-time calibration sweep sequencer for the ACC demo-flag trim stage
module acc_trim_cal_ctrl #(
    parameter int SETTLE_CYC  = 64,
    parameter int WIN_FLAGS   = 32,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        cal_start_i,
    input  logic        cal_abort_i,
    input  logic [15:0] sweep_start_i,
    input  logic [15:0] sweep_step_i,
    input  logic [7:0]  sweep_num_i,
    input  logic [15:0] manual_pose_i,
    input  logic [15:0] manual_nege_i,
    input  logic        acc_demo_flag_i,
    input  logic [31:0] acc_phase_cnt_i,
    output logic        pmt_scan_en_o,
    output logic [15:0] trim_pose_o,
    output logic [15:0] trim_nege_o,
    output logic        cal_busy_o,
    output logic        cal_done_o,
    output logic        cal_err_o,
    output logic [15:0] best_val_o,
    output logic [16:0] best_score_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_APPLY  = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_ARM    = 3'd3;
    localparam logic [2:0] S_MEAS   = 3'd4;
    localparam logic [2:0] S_SCORE  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam int SW = $clog2(SETTLE_CYC + 1);

    logic [2:0]    r_state;
    logic [15:0]   r_step;
    logic [7:0]    r_num;
    logic [7:0]    r_idx;
    logic [15:0]   r_cur_val;
    logic [SW-1:0] r_settle_cnt;
    logic [7:0]    r_edge_cnt;
    logic          r_tail;
    logic [23:0]   r_to_cnt;
    logic          r_flag_sync;
    logic          r_flag_d0;
    logic          r_flag_d1;
    logic [15:0]   r_best_val;
    logic [16:0]   r_best_score;
    logic          r_err;
    logic          r_use_best;
    logic [15:0]   r_trim_pose;
    logic [15:0]   r_trim_nege;

    logic          w_flag_edge;
    logic [16:0]   w_score;
    logic [16:0]   w_next_val;
    logic          w_last;

    assign w_flag_edge = r_flag_d0 & ~r_flag_d1;
    assign w_score     = {1'b0, acc_phase_cnt_i[31:16]} + {1'b0, acc_phase_cnt_i[15:0]};
    assign w_next_val  = {1'b0, r_cur_val} + {1'b0, r_step};
    assign w_last      = ((r_idx + 8'd1) == r_num);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_num        <= '0;
            r_idx        <= '0;
            r_cur_val    <= '0;
            r_settle_cnt <= '0;
            r_edge_cnt   <= '0;
            r_tail       <= 1'b0;
            r_to_cnt     <= '0;
            r_flag_sync  <= 1'b0;
            r_flag_d0    <= 1'b0;
            r_flag_d1    <= 1'b0;
            r_best_val   <= '0;
            r_best_score <= 17'h1FFFF;
            r_err        <= 1'b0;
            r_use_best   <= 1'b0;
            r_trim_pose  <= '0;
            r_trim_nege  <= '0;
        end else begin
            r_flag_sync <= acc_demo_flag_i;
            r_flag_d0   <= r_flag_sync;
            r_flag_d1   <= r_flag_d0;
            // Abort outranks every state transition; IDLE then restores manual trims.
            if (r_state != S_IDLE && cal_abort_i) begin
                r_state <= S_IDLE;
                r_err   <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cal_start_i && !cal_abort_i) begin
                            r_use_best  <= 1'b0;
                            r_trim_pose <= manual_pose_i;
                            r_trim_nege <= manual_nege_i;
                            if (sweep_num_i == 8'd0) begin
                                r_err <= 1'b1;
                            end else begin
                                r_err        <= 1'b0;
                                r_step       <= sweep_step_i;
                                r_num        <= sweep_num_i;
                                r_idx        <= '0;
                                r_cur_val    <= sweep_start_i;
                                r_best_score <= 17'h1FFFF;
                                r_state      <= S_APPLY;
                            end
                        end else if (r_use_best) begin
                            r_trim_pose <= r_best_val;
                            r_trim_nege <= r_best_val;
                        end else begin
                            r_trim_pose <= manual_pose_i;
                            r_trim_nege <= manual_nege_i;
                        end
                    end
                    S_APPLY: begin
                        r_trim_pose  <= r_cur_val;
                        r_trim_nege  <= r_cur_val;
                        r_settle_cnt <= '0;
                        r_state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle_cnt == SW'(SETTLE_CYC - 1)) begin
                            r_state <= S_ARM;
                        end else begin
                            r_settle_cnt <= r_settle_cnt + 1'b1;
                        end
                    end
                    S_ARM: begin
                        r_edge_cnt <= '0;
                        r_tail     <= 1'b0;
                        r_to_cnt   <= '0;
                        r_state    <= S_MEAS;
                    end
                    S_MEAS: begin
                        // Two tail cycles let the trim stage's counters settle before scoring.
                        if (r_edge_cnt == 8'(WIN_FLAGS)) begin
                            if (r_tail) begin
                                r_state <= S_SCORE;
                            end else begin
                                r_tail <= 1'b1;
                            end
                        end else if (w_flag_edge) begin
                            r_edge_cnt <= r_edge_cnt + 8'd1;
                            r_to_cnt   <= '0;
                        end else if (r_to_cnt == 24'(TIMEOUT_CYC)) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 24'd1;
                        end
                    end
                    S_SCORE: begin
                        if (w_score < r_best_score) begin
                            r_best_score <= w_score;
                            r_best_val   <= r_cur_val;
                        end
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else if (w_next_val[16]) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_cur_val <= w_next_val[15:0];
                            r_idx     <= r_idx + 8'd1;
                            r_state   <= S_APPLY;
                        end
                    end
                    S_DONE: begin
                        r_use_best <= 1'b1;
                        r_state    <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign pmt_scan_en_o = (r_state == S_ARM) || (r_state == S_MEAS);
    assign trim_pose_o   = r_trim_pose;
    assign trim_nege_o   = r_trim_nege;
    assign cal_busy_o    = (r_state != S_IDLE);
    assign cal_done_o    = (r_state == S_DONE);
    assign cal_err_o     = r_err;
    assign best_val_o    = r_best_val;
    assign best_score_o  = r_best_score;

endmodule
